// File: rtl/ahb5_mem_subordinate_pkg.sv
// ---------------------------------------------------------------------------
// ahb5_mem_subordinate_pkg
//   Shared types and constants for the AHB5 memory-backed subordinate:
//   transfer-type encoding, HSIZE codes, HRESP codes, the FSM state
//   enumeration, a debug struct that exposes FSM internals, and an
//   alignment helper.
// ---------------------------------------------------------------------------
package ahb5_mem_subordinate_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Debug view of the FSM and the captured address-phase attributes.
    typedef struct packed {
        state_t     state;
        logic [3:0] wait_cnt;
        logic [3:0] hprot;
        logic       nonsec;
        logic       write;
    } dbg_t;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (hsize)
            HSIZE_HALF: mis = addr_lo[0];
            HSIZE_WORD: mis = (addr_lo != 2'b00);
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb5_byte_lane_gen.sv
// ---------------------------------------------------------------------------
// ahb5_byte_lane_gen
//   Combinational byte-strobe generator for a 32-bit little-endian AHB bus.
//   Ports:
//     i_hsize   [2:0]  transfer size (0=byte, 1=half, 2=word; others -> no lanes)
//     i_addr_lo [1:0]  low address bits selecting the lane(s)
//     o_strb    [3:0]  one bit per byte lane, bit 0 = HWDATA[7:0]
// ---------------------------------------------------------------------------
module ahb5_byte_lane_gen
    import ahb5_mem_subordinate_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strb
);

    always_comb begin
        o_strb = 4'b0000;
        case (i_hsize)
            HSIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
            HSIZE_HALF: o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: o_strb = 4'b1111;
            default:    o_strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb5_mem_subordinate.sv
// ---------------------------------------------------------------------------
// ahb5_mem_subordinate
//   AHB5 subordinate backed by a word-addressed memory. Accepts pipelined
//   address/data phases, inserts WAIT_STATES wait cycles per OKAY transfer,
//   and answers range/size/alignment/security violations with a two-cycle
//   ERROR response. Errored transfers never touch memory.
//
//   Handshake: an address phase is taken on a rising edge where
//   HSEL & HREADY & HTRANS[1] and the subordinate is not stalling (state
//   IDLE, DATA or ERR2). The data phase completes on the first edge where
//   HREADYOUT=1; write data is sampled and read data is presented on that
//   cycle only.
//
//   Ports:
//     HCLK, HRESETn        clock, asynchronous active-low reset
//     HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HNONSEC   address phase
//     HWDATA               write data (data phase)
//     HREADY               bus ready (previous transfer completed)
//     HREADYOUT, HRESP     subordinate ready / response (0=OKAY 1=ERROR)
//     HRDATA               read data
//     o_dbg                FSM state, wait counter and captured attributes
// ---------------------------------------------------------------------------
module ahb5_mem_subordinate
    import ahb5_mem_subordinate_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter bit SECURE_ONLY = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HNONSEC,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output dbg_t                  o_dbg
);

    localparam int                  IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

    // Registers
    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_strb;
    logic                  r_write;
    logic                  r_nonsec;
    logic [3:0]            r_hprot;
    logic [DATA_WIDTH-1:0] r_hrdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Wires
    htrans_t               w_htrans;
    logic                  w_can_take;
    logic                  w_accept;
    logic                  w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [3:0]            w_strb;
    state_t                w_nxt_state;
    logic [3:0]            w_nxt_cnt;
    logic                  w_wr_active;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_load_rd;

    assign w_htrans   = htrans_t'(HTRANS);
    assign w_can_take = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_accept   = HSEL && HREADY && w_can_take &&
                        ((w_htrans == HTRANS_NONSEQ) || (w_htrans == HTRANS_SEQ));

    assign w_err = (HADDR >= LP_LIMIT) ||
                   (HSIZE > HSIZE_WORD) ||
                   is_misaligned(HSIZE, HADDR[1:0]) ||
                   (SECURE_ONLY && HNONSEC);

    assign w_idx = HADDR[IDX_W+1:2];

    ahb5_byte_lane_gen u_lane_gen (
        .i_hsize  (HSIZE),
        .i_addr_lo(HADDR[1:0]),
        .o_strb   (w_strb)
    );

    // FSM next state and bus outputs
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_wait_cnt;
        HREADYOUT   = 1'b1;
        HRESP       = HRESP_OKAY;
        case (r_state)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wait_cnt == 4'd0) begin
                    w_nxt_state = ST_DATA;
                end else begin
                    w_nxt_cnt = r_wait_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = HRESP_ERROR;
                w_nxt_state = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all drive HREADYOUT=1 and may take a new address phase.
                if (r_state == ST_ERR2) begin
                    HRESP = HRESP_ERROR;
                end
                if (w_accept) begin
                    if (w_err) begin
                        w_nxt_state = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_nxt_state = ST_WAIT;
                        // Counting down to 0 inclusive yields exactly WAIT_STATES stall cycles.
                        w_nxt_cnt   = 4'(WAIT_STATES - 1);
                    end else begin
                        w_nxt_state = ST_DATA;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
        endcase
    end

    // Write data phase: merge HWDATA lanes into the stored word.
    assign w_wr_active = (r_state == ST_DATA) && r_write;

    always_comb begin
        w_wr_merged = r_mem[r_idx];
        for (int i = 0; i < 4; i++) begin
            if (r_strb[i]) begin
                w_wr_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Read data is registered on the edge entering DATA. With zero wait
    // states that edge is the read's own address phase, which may coincide
    // with a write's data phase to the same word: forward the merged word.
    assign w_rd_idx  = (r_state == ST_WAIT) ? r_idx : w_idx;
    assign w_rd_word = (w_wr_active && (r_idx == w_rd_idx)) ? w_wr_merged : r_mem[w_rd_idx];
    assign w_load_rd = ((r_state == ST_WAIT) && (r_wait_cnt == 4'd0) && !r_write) ||
                       (w_accept && !w_err && (WAIT_STATES == 0) && !HWRITE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_idx      <= '0;
            r_strb     <= 4'b0000;
            r_write    <= 1'b0;
            r_nonsec   <= 1'b0;
            r_hprot    <= 4'd0;
            r_hrdata   <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_wait_cnt <= w_nxt_cnt;
            if (w_accept) begin
                r_idx    <= w_idx;
                r_strb   <= w_strb;
                r_write  <= HWRITE;
                r_nonsec <= HNONSEC;
                r_hprot  <= HPROT;
            end
            if (w_load_rd) begin
                r_hrdata <= w_rd_word;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge HCLK) begin
        if (w_wr_active) begin
            r_mem[r_idx] <= w_wr_merged;
        end
    end

    assign HRDATA = r_hrdata;

    assign o_dbg.state    = r_state;
    assign o_dbg.wait_cnt = r_wait_cnt;
    assign o_dbg.hprot    = r_hprot;
    assign o_dbg.nonsec   = r_nonsec;
    assign o_dbg.write    = r_write;

endmodule

// File: tb/tb_ahb5_mem_subordinate.sv
// ---------------------------------------------------------------------------
// tb_ahb5_mem_subordinate
//   Two subordinates (WAIT_STATES=0 and WAIT_STATES=3) share one set of
//   manager-side signals; tgt selects which one receives HSEL. Each DUT's
//   HREADY is its own HREADYOUT (single-subordinate bus).
// ---------------------------------------------------------------------------
module tb_ahb5_mem_subordinate;
    import ahb5_mem_subordinate_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus ----------------
    logic        b_hsel    = 1'b0;
    logic [31:0] b_haddr   = 32'd0;
    logic [1:0]  b_htrans  = 2'b00;
    logic        b_hwrite  = 1'b0;
    logic [2:0]  b_hsize   = 3'd0;
    logic [3:0]  b_hprot   = 4'd0;
    logic        b_hnonsec = 1'b0;
    logic [31:0] b_hwdata  = 32'd0;
    int          tgt       = 0;

    logic        sel0, sel3;
    logic        ro0, rsp0, ro3, rsp3;
    logic [31:0] rd0, rd3;
    dbg_t        dbg0, dbg3;

    assign sel0 = b_hsel && (tgt == 0);
    assign sel3 = b_hsel && (tgt == 1);

    ahb5_mem_subordinate #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(b_haddr), .HTRANS(b_htrans),
        .HWRITE(b_hwrite), .HSIZE(b_hsize), .HPROT(b_hprot), .HNONSEC(b_hnonsec),
        .HWDATA(b_hwdata), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0),
        .o_dbg(dbg0)
    );

    ahb5_mem_subordinate #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(b_haddr), .HTRANS(b_htrans),
        .HWRITE(b_hwrite), .HSIZE(b_hsize), .HPROT(b_hprot), .HNONSEC(b_hnonsec),
        .HWDATA(b_hwdata), .HREADY(ro3), .HREADYOUT(ro3), .HRESP(rsp3), .HRDATA(rd3),
        .o_dbg(dbg3)
    );

    // ---------------- scoreboard ----------------
    // Entry: [37]=is_read [36]=resp [35:32]=wait cycles [31:0]=read data
    logic [37:0] exp_q[$];
    string       name_q[$];
    logic [31:0] m0 [256];
    logic [31:0] m3 [256];
    bit          have_dp  = 1'b0;
    int          dp_waits = 0;
    int          dp_bad   = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    string       cur_name = "";

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%s] got 0x%0h expected 0x%0h", tag, cur_name, got, exp);
        end
    endtask

    // Samples outputs at the negedge (stable until the next posedge) and
    // retires the pending data phase when HREADYOUT is high.
    task automatic sample_cycle(output logic rdy);
        logic        rsp;
        logic [31:0] rd;
        logic [37:0] e;
        @(negedge clk);
        rdy = (tgt == 0) ? ro0 : ro3;
        rsp = (tgt == 0) ? rsp0 : rsp3;
        rd  = (tgt == 0) ? rd0 : rd3;
        if (have_dp && exp_q.size() > 0) begin
            if (!rdy) begin
                dp_waits++;
                if (rsp !== exp_q[0][36]) dp_bad++;
            end else begin
                e        = exp_q.pop_front();
                cur_name = name_q.pop_front();
                check_eq("waits", 64'(dp_waits), 64'(e[35:32]));
                check_eq("resp", 64'(rsp), 64'(e[36]));
                check_eq("wait_resp", 64'(dp_bad), 64'd0);
                if (e[37]) check_eq("rdata", 64'(rd), 64'(e[31:0]));
                have_dp = 1'b0;
            end
        end
    endtask

    // Drives one address phase (held until the bus is ready), pushes the
    // expected outcome from the memory model, then moves into the data phase.
    task automatic issue(input string name, input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input logic ns);
        logic        rdy;
        logic        err;
        logic [37:0] e;
        logic [31:0] w;
        int          idx, nb, ws, k, lo;
        b_hsel    = sel;
        b_htrans  = tr;
        b_hwrite  = wr;
        b_hsize   = sz;
        b_haddr   = a;
        b_hnonsec = ns;
        b_hprot   = 4'($urandom_range(0, 15));
        k = 0;
        sample_cycle(rdy);
        while (!rdy && k < 40) begin
            @(posedge clk); #1;
            sample_cycle(rdy);
            k++;
        end
        if (!rdy) check_eq("ready_timeout", 64'(rdy), 64'd1);
        ws = (tgt == 0) ? 0 : 3;
        if (!(sel && tr[1])) begin
            e = {1'b0, 1'b0, 4'd0, 32'd0};
        end else begin
            err = (a >= 32'h400) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
                  (sz == 3'd2 && a[1:0] != 2'b00) || ns;
            if (err) begin
                e = {1'b0, 1'b1, 4'd1, 32'd0};
            end else begin
                idx = int'(a[9:2]);
                lo  = int'(a[1:0]);
                w   = (tgt == 0) ? m0[idx] : m3[idx];
                if (wr) begin
                    nb = 1 << sz;
                    for (int i = 0; i < 4; i++)
                        if (i >= lo && i < lo + nb) w[8*i +: 8] = wd[8*i +: 8];
                    if (tgt == 0) m0[idx] = w; else m3[idx] = w;
                    e = {1'b0, 1'b0, 4'(ws), 32'd0};
                end else begin
                    e = {1'b1, 1'b0, 4'(ws), w};
                end
            end
        end
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk); #1;
        have_dp  = 1'b1;
        dp_waits = 0;
        dp_bad   = 0;
        b_hwdata = (sel && tr[1] && wr) ? wd : $urandom();
    endtask

    task automatic drain();
        logic rdy;
        int   k;
        k        = 0;
        b_hsel   = 1'b0;
        b_htrans = 2'b00;
        while (have_dp && k < 40) begin
            sample_cycle(rdy);
            k++;
            if (have_dp) begin
                @(posedge clk); #1;
            end
        end
        if (have_dp) check_eq("drain_timeout", 64'(have_dp), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;

        // Reset state
        cur_name = "reset";
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hreadyout", 64'(ro0), 64'd1);
        check_eq("rst_hresp", 64'(rsp0), 64'd0);
        check_eq("rst_hrdata", 64'(rd0), 64'd0);
        check_eq("rst_state", 64'(dbg0.state), 64'(ST_IDLE));
        check_eq("rst_wait_cnt", 64'(dbg3.wait_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero wait states: write then back-to-back read of the same word
        tgt = 0;
        issue("ws0_wr", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, 0);
        issue("ws0_rd_fwd", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0);
        // Byte and halfword lanes
        issue("init20", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h11223344, 0);
        issue("byte23", 1, HTRANS_SEQ, 1, HSIZE_BYTE, 32'h23, 32'hAA000000, 0);
        issue("rd20", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0, 0);
        issue("init30", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h30, 32'h11223344, 0);
        issue("half32", 1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h32, 32'hBEEF0000, 0);
        issue("rd30", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0, 0);
        issue("rd_byte21", 1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h21, 32'h0, 0);
        drain();
        cur_name = "lane_values";
        check_eq("byte_merge_model", 64'(m0[8]), 64'hAA223344);
        check_eq("half_merge_model", 64'(m0[12]), 64'hBEEF3344);

        // Errors, each followed by a NONSEQ taken in ERR2
        issue("init00", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0, 32'h55AA55AA, 0);
        issue("err_range", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h400, 32'h12345678, 0);
        issue("rd_after_range", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("err_misalign", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h2, 32'h12345678, 0);
        issue("rd_after_mis", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("err_size3", 1, HTRANS_NONSEQ, 1, 3'd3, 32'h0, 32'h12345678, 0);
        issue("rd_after_sz", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("err_nonsec", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0, 32'h12345678, 1);
        issue("rd_after_ns", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("err_half_odd", 1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h1, 32'h12345678, 0);
        // Idle/busy/unselected transfers with HWRITE=1 must not write
        issue("idle_sel", 1, HTRANS_IDLE, 1, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("busy_sel", 1, HTRANS_BUSY, 1, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("nonseq_unsel", 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0, 32'h0, 0);
        issue("rd_unchanged", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0, 0);
        drain();

        // Three wait states
        tgt = 1;
        issue("ws3_wr", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hCAFEF00D, 0);
        issue("ws3_rd", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0);
        issue("ws3_byte", 1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h11, 32'h00005A00, 0);
        issue("ws3_rd2", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0);
        issue("ws3_err", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h7FC, 32'h0, 1);
        issue("ws3_rd3", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0);
        drain();

        // Reset in the middle of a wait sequence
        issue("rst_mid_wait", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0);
        b_hsel   = 1'b0;
        b_htrans = 2'b00;
        cur_name = "reset_mid_wait";
        check_eq("pre_rst_state", 64'(dbg3.state), 64'(ST_WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_hreadyout", 64'(ro3), 64'd1);
        check_eq("rst_hresp", 64'(rsp3), 64'd0);
        check_eq("rst_hrdata3", 64'(rd3), 64'd0);
        check_eq("rst_hrdata0", 64'(rd0), 64'd0);
        check_eq("rst_wait_cnt", 64'(dbg3.wait_cnt), 64'd0);
        exp_q.delete();
        name_q.delete();
        have_dp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_state", 64'(dbg3.state), 64'(ST_IDLE));
        issue("rd_after_rst", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 0);
        drain();

        // Randomised traffic on both subordinates
        for (int t = 0; t < 2; t++) begin
            tgt = t;
            for (int wi = 0; wi < 8; wi++)
                issue("rnd_init", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(wi * 4), $urandom(), 0);
            for (int n = 0; n < 30; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    issue("rnd_range", 1, HTRANS_NONSEQ, 1'($urandom_range(0, 1)), HSIZE_WORD,
                          32'h400 + 32'($urandom_range(0, 255) * 4), $urandom(), 0);
                end else if (r == 1) begin
                    issue("rnd_nonsec", 1, HTRANS_NONSEQ, 1, HSIZE_WORD,
                          32'($urandom_range(0, 7) * 4), $urandom(), 1);
                end else if (r == 2) begin
                    issue("rnd_busy", 1, HTRANS_BUSY, 1, HSIZE_WORD,
                          32'($urandom_range(0, 7) * 4), 32'h0, 0);
                end else begin
                    sz = 3'($urandom_range(0, 2));
                    a  = 32'($urandom_range(0, 7) * 4);
                    if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
                    if (sz == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
                    issue("rnd_ok", 1, HTRANS_NONSEQ, 1'($urandom_range(0, 1)), sz, a, $urandom(), 0);
                end
            end
            for (int wi = 0; wi < 8; wi++)
                issue("rnd_final_rd", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'(wi * 4), 32'h0, 0);
            drain();
        end

        cur_name = "end";
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout [%s] got 0x0 expected 0x1", cur_name);
        $fatal(1, "simulation time limit");
    end

endmodule
